// File: rtl/reloj_soc_pkg.sv
// reloj_soc_pkg
//   Shared definitions for the reloj_soc timer-facing logic: interval-timer
//   register map, control-register bit positions, the control words written
//   by the tick master, and the tick-master FSM state type.
//   No ports (package).
package reloj_soc_pkg;

  // Interval-timer word addresses
  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_SNAPL   = 3'd4;
  localparam logic [2:0] TMR_SNAPH   = 3'd5;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Start continuous with IRQ enabled (0x0007), and stop (0x0008)
  localparam logic [15:0] CTRL_RUN_WORD  = (16'd1 << CTRL_START) | (16'd1 << CTRL_CONT) |
                                           (16'd1 << CTRL_ITO);
  localparam logic [15:0] CTRL_STOP_WORD = (16'd1 << CTRL_STOP);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_RUN      = 3'd2,
    ST_ACK      = 3'd3,
    ST_CHK      = 3'd4,
    ST_CHK_WAIT = 3'd5,
    ST_STOP     = 3'd6
  } tm_state_t;

  function automatic logic hms_in_range(input logic [4:0] h, input logic [5:0] m,
                                        input logic [5:0] s);
    return (h <= 5'd23) && (m <= 6'd59) && (s <= 6'd59);
  endfunction

endpackage

// File: rtl/reloj_soc_hms_counter.sv
// reloj_soc_hms_counter
//   Divides timer timeouts into 1 s ticks and keeps hh:mm:ss time-of-day.
//   Ports:
//     clk, reset_n            clock, async active-low reset
//     sub_inc                 one pulse per acknowledged timer timeout
//     time_set                1-cycle load request for set_hour/set_min/set_sec
//     set_hour/min/sec        time to load (whole set ignored if any field out of range)
//     tick_1s                 1-cycle pulse on each second increment
//     hour/minute/second      current time
module reloj_soc_hms_counter
  import reloj_soc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sub_inc,
  input  logic       time_set,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic       tick_1s,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);

  logic [SUB_W-1:0] sub_cnt;
  logic             set_ok;

  assign set_ok = time_set && hms_in_range(set_hour, set_min, set_sec);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_cnt <= '0;
      tick_1s <= 1'b0;
      hour    <= '0;
      minute  <= '0;
      second  <= '0;
    end else begin
      tick_1s <= 1'b0;
      // A valid set takes priority over a coincident second increment,
      // which is then dropped together with its tick.
      if (set_ok) begin
        sub_cnt <= '0;
        hour    <= set_hour;
        minute  <= set_min;
        second  <= set_sec;
      end else if (sub_inc) begin
        if (sub_cnt == SUB_MAX) begin
          sub_cnt <= '0;
          tick_1s <= 1'b1;
          if (second == 6'd59) begin
            second <= '0;
            if (minute == 6'd59) begin
              minute <= '0;
              hour   <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
              minute <= minute + 6'd1;
            end
          end else begin
            second <= second + 6'd1;
          end
        end else begin
          sub_cnt <= sub_cnt + SUB_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/reloj_soc_tick_master.sv
// reloj_soc_tick_master
//   Avalon-MM initiator for the SoC interval timer. Starts the timer in
//   continuous mode with IRQ enabled, clears TO on every timeout, reads
//   STATUS back to confirm the clear, and feeds timeouts to the h/m/s counter.
//   Ports:
//     clk, reset_n                       clock, async active-low reset
//     enable                             level; 1 = run timer, 0 = stop timer
//     time_set, set_hour/min/sec         time load request and value
//     irq                                timer interrupt
//     av_address/chipselect/write_n/
//     av_writedata/av_readdata           Avalon-MM master port (no waitrequest)
//     tick_1s, hour, minute, second      time-of-day outputs
//     running                            timer started and not stopped
//     ack_error                          sticky: TO still set after the clear
//
//   state    | meaning
//   IDLE     | timer stopped, waiting for enable
//   START    | write CONTROL = START|CONT|ITO
//   RUN      | timer running, waiting for irq or enable drop
//   ACK      | write STATUS = 0 (clear TO), count one timeout
//   CHK      | read STATUS address phase
//   CHK_WAIT | wait out read latency, sample TO
//   STOP     | write CONTROL = STOP
module reloj_soc_tick_master
  import reloj_soc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int READ_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        time_set,
  input  logic [4:0]  set_hour,
  input  logic [5:0]  set_min,
  input  logic [5:0]  set_sec,
  input  logic        irq,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  output logic        tick_1s,
  output logic [4:0]  hour,
  output logic [5:0]  minute,
  output logic [5:0]  second,
  output logic        running,
  output logic        ack_error
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  tm_state_t  state, state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic       sub_inc;
  logic       sample_to;
  logic       rd_unused_bits;

  assign rd_unused_bits = ^av_readdata[15:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      ack_error <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_START) running <= 1'b1;
      if (state == ST_STOP)  running <= 1'b0;
      if (sample_to && av_readdata[0]) ack_error <= 1'b1;
      // Down-counter over the remaining read-latency cycles; terminal count 0
      if (state == ST_CHK) begin
        lat_cnt <= LAT_W'(READ_LATENCY - 1);
      end else if ((state == ST_CHK_WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
    end
  end

  // Bus outputs decode straight from state so that reset idles them at once.
  always_comb begin
    state_nxt     = state;
    av_address    = '0;
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_writedata  = '0;
    sub_inc       = 1'b0;
    sample_to     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_START;
      end
      ST_START: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = TMR_CONTROL;
        av_writedata  = CTRL_RUN_WORD;
        state_nxt     = ST_RUN;
      end
      ST_RUN: begin
        // Pending timeouts are serviced before honouring a stop request.
        if (irq)          state_nxt = ST_ACK;
        else if (!enable) state_nxt = ST_STOP;
      end
      ST_ACK: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = TMR_STATUS;
        av_writedata  = 16'h0000;
        sub_inc       = 1'b1;
        state_nxt     = ST_CHK;
      end
      ST_CHK: begin
        av_chipselect = 1'b1;
        av_address    = TMR_STATUS;
        state_nxt     = ST_CHK_WAIT;
      end
      ST_CHK_WAIT: begin
        if (lat_cnt == '0) begin
          sample_to = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_STOP: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = TMR_CONTROL;
        av_writedata  = CTRL_STOP_WORD;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  reloj_soc_hms_counter #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_hms (
    .clk      (clk),
    .reset_n  (reset_n),
    .sub_inc  (sub_inc),
    .time_set (time_set),
    .set_hour (set_hour),
    .set_min  (set_min),
    .set_sec  (set_sec),
    .tick_1s  (tick_1s),
    .hour     (hour),
    .minute   (minute),
    .second   (second)
  );

endmodule

// File: tb/tb_reloj_soc_tick_master.sv
module tb_reloj_soc_tick_master;

  localparam int TPS = 4;
  localparam int RL  = 1;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        time_set;
  logic [4:0]  set_hour;
  logic [5:0]  set_min;
  logic [5:0]  set_sec;
  logic        irq;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        tick_1s;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic        running;
  logic        ack_error;

  reloj_soc_tick_master #(.TICKS_PER_SEC(TPS), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .time_set(time_set),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .irq(irq),
    .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .tick_1s(tick_1s),
    .hour(hour), .minute(minute), .second(second), .running(running),
    .ack_error(ack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [2:0] addr; logic [15:0] data; } bus_t;
  typedef struct packed { logic [4:0] h; logic [5:0] m; logic [5:0] s; } hms_t;

  bus_t bus_q[$];
  hms_t tick_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;
  logic force_err;

  // Reference time model: sub-tick count and time of day as plain integers
  int m_sub = 0, m_h = 0, m_m = 0, m_s = 0;

  function automatic bus_t mk_bus(input logic wr, input logic [2:0] a, input logic [15:0] d);
    bus_t b;
    b.wr = wr; b.addr = a; b.data = d;
    return b;
  endfunction

  // Timer slave: registered readdata (one-cycle read latency), TO mirrored by irq
  always @(posedge clk) begin
    if (av_chipselect && av_write_n && av_address == 3'd0)
      av_readdata <= {15'd0, irq | force_err};
    else
      av_readdata <= 16'h0000;
  end

  // Monitor: pops expectations whenever the DUT presents a bus cycle or a tick
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (av_chipselect) begin
        if (bus_q.size() == 0) begin
          failures++;
          $display("FAIL bus_unexpected got addr=%0d write_n=%0b data=%h, none expected",
                   av_address, av_write_n, av_writedata);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          if (av_address != e.addr || av_write_n != !e.wr || (e.wr && av_writedata != e.data)) begin
            failures++;
            $display("FAIL bus_txn got addr=%0d write_n=%0b data=%h exp addr=%0d write_n=%0b data=%h",
                     av_address, av_write_n, av_writedata, e.addr, !e.wr, e.data);
          end
        end
      end else if (av_address != 3'd0 || av_writedata != 16'h0 || av_write_n != 1'b1) begin
        failures++;
        $display("FAIL bus_idle got addr=%0d write_n=%0b data=%h exp 0/1/0000",
                 av_address, av_write_n, av_writedata);
      end
      if (tick_1s) begin
        checks++;
        if (tick_q.size() == 0) begin
          failures++;
          $display("FAIL tick_unexpected got %0d:%0d:%0d, no tick expected", hour, minute, second);
        end else begin
          hms_t t;
          t = tick_q.pop_front();
          if (hour != t.h || minute != t.m || second != t.s) begin
            failures++;
            $display("FAIL tick_time got %0d:%0d:%0d exp %0d:%0d:%0d",
                     hour, minute, second, t.h, t.m, t.s);
          end
        end
      end
    end
  end

  task automatic tick_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %0b exp %0b", name, got, exp);
    end
  endtask

  task automatic check_time(input string name);
    checks++;
    if (hour != 5'(m_h) || minute != 6'(m_m) || second != 6'(m_s)) begin
      failures++;
      $display("FAIL %s got %0d:%0d:%0d exp %0d:%0d:%0d", name, hour, minute, second,
               m_h, m_m, m_s);
    end
  endtask

  task automatic model_timeout();
    int t;
    m_sub++;
    if (m_sub == TPS) begin
      m_sub = 0;
      t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = t / 3600;
      m_m = (t / 60) % 60;
      m_s = t % 60;
      tick_q.push_back(hms_t'{h: 5'(m_h), m: 6'(m_m), s: 6'(m_s)});
    end
  endtask

  task automatic start_run();
    bus_q.push_back(mk_bus(1'b1, 3'd1, 16'h0007));
    enable = 1'b1;
    tick_cycles(1);
    check1("running_early", running, 1'b0);
    tick_cycles(1);
    check1("running_on", running, 1'b1);
  endtask

  task automatic stop_run();
    bus_q.push_back(mk_bus(1'b1, 3'd1, 16'h0008));
    enable = 1'b0;
    for (int i = 0; i < 12 && running; i++) tick_cycles(1);
    check1("running_off", running, 1'b0);
  endtask

  // One timer timeout: raise irq, wait for the DUT's clear write, drop irq.
  task automatic do_timeout(input bit err, input bit drop_en, input bit coin,
                            input int h, input int m, input int s, input int gap);
    bit found = 0;
    bus_q.push_back(mk_bus(1'b1, 3'd0, 16'h0000));
    bus_q.push_back(mk_bus(1'b0, 3'd0, 16'h0000));
    if (drop_en) bus_q.push_back(mk_bus(1'b1, 3'd1, 16'h0008));
    force_err = err;
    irq = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (av_chipselect && !av_write_n && av_address == 3'd0) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL ack_wait got no clear write within 40 cycles, exp one");
    end
    if (coin) begin
      time_set = 1'b1;
      set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    end
    if (drop_en) enable = 1'b0;
    tick_cycles(1);
    irq = 1'b0;
    time_set = 1'b0;
    if (coin) begin
      m_sub = 0; m_h = h; m_m = m; m_s = s;
    end else begin
      model_timeout();
    end
    tick_cycles(1);
    force_err = 1'b0;
    if (gap > 1) tick_cycles(gap - 1);
  endtask

  task automatic do_set(input int h, input int m, input int s);
    time_set = 1'b1;
    set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    tick_cycles(1);
    time_set = 1'b0;
    if (h <= 23 && m <= 59 && s <= 59) begin
      m_h = h; m_m = m; m_s = s; m_sub = 0;
    end
    tick_cycles(1);
    check_time("time_after_set");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; time_set = 1'b0; irq = 1'b0; force_err = 1'b0;
    set_hour = '0; set_min = '0; set_sec = '0;
    tick_cycles(3);
    check1("rst_cs", av_chipselect, 1'b0);
    check1("rst_write_n", av_write_n, 1'b1);
    check1("rst_running", running, 1'b0);
    check1("rst_ack_error", ack_error, 1'b0);
    check1("rst_tick", tick_1s, 1'b0);
    check_time("rst_time");
    reset_n = 1'b1;
    mon_en = 1;
    tick_cycles(2);

    // Start, first acknowledge with clean read-back
    start_run();
    do_timeout(0, 0, 0, 0, 0, 0, 3);
    check1("ack_error_clean", ack_error, 1'b0);

    // Remaining timeouts of the first second, then the midnight rollover
    repeat (3) do_timeout(0, 0, 0, 0, 0, 0, $urandom_range(1, 4));
    check_time("time_one_sec");
    do_set(23, 59, 59);
    repeat (4) do_timeout(0, 0, 0, 0, 0, 0, $urandom_range(1, 4));
    check_time("time_midnight");

    // Set coincident with a second increment, then an out-of-range set
    while (m_sub != TPS - 1) do_timeout(0, 0, 0, 0, 0, 0, 2);
    do_timeout(0, 0, 1, 12, 34, 56, 2);
    check_time("time_coincident_set");
    do_set(24, 0, 0);
    check_time("time_bad_set");

    // Randomized mix of timeouts, sets and stop/start
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        do_timeout(0, 0, 0, 0, 0, 0, $urandom_range(1, 5));
      end else if (r < 8) begin
        do_set($urandom_range(0, 25), $urandom_range(0, 61), $urandom_range(0, 61));
      end else begin
        stop_run();
        tick_cycles($urandom_range(0, 3));
        start_run();
      end
    end
    check_time("time_after_random");
    check1("ack_error_after_random", ack_error, 1'b0);

    // Read-back still shows TO
    do_timeout(1, 0, 0, 0, 0, 0, 3);
    check1("ack_error_set", ack_error, 1'b1);

    // enable dropped during ACK: finish the check, then stop
    do_timeout(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12 && running; i++) tick_cycles(1);
    check1("running_off_after_ack", running, 1'b0);
    tick_cycles(4);
    check1("ack_error_held", ack_error, 1'b1);
    check_time("time_final");

    checks++;
    if (bus_q.size() != 0 || tick_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained got bus=%0d tick=%0d exp 0/0", bus_q.size(), tick_q.size());
    end

    // Reset in the middle of a bus write: outputs idle immediately
    mon_en = 0;
    enable = 1'b1;
    tick_cycles(1);
    check1("mid_cs_before_reset", av_chipselect, 1'b1);
    reset_n = 1'b0;
    #1;
    check1("mid_reset_cs", av_chipselect, 1'b0);
    check1("mid_reset_write_n", av_write_n, 1'b1);
    check1("mid_reset_ack_error", ack_error, 1'b0);
    check1("mid_reset_running", running, 1'b0);
    tick_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
